// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver feeding a receive FIFO, read over the
// CPU I/O bus through data/status select strobes. Bus writes are ignored.
module uart_rx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    inout  wire  [7:0] io_bus,
    input  logic       sel_data,
    input  logic       sel_status,
    input  logic       rnw
);

    localparam int unsigned CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned COUNT_W = AW + 1;
    localparam logic [CW-1:0]      HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]      FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [COUNT_W-1:0] DEPTH_C = COUNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          shift_q, shift_d;
    logic                rx_meta_q, rx_s_q, rx_prev_q;
    logic                rd_data_prev_q, rd_stat_prev_q;
    logic                ferr_q, ferr_d, ovr_q, ovr_d;
    logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic [7:0]          mem_q [FIFO_DEPTH];

    logic       start_edge, push_req, ferr_set;
    logic       rd_data_now, rd_stat_now, rd_data_end, rd_stat_end;
    logic       empty, full, pop, push_ok, ovr_set;
    logic       bus_en;
    logic [7:0] bus_val, status;

    assign start_edge  = rx_prev_q & ~rx_s_q;
    assign rd_data_now = sel_data & rnw;
    assign rd_stat_now = sel_status & rnw;
    assign rd_data_end = rd_data_prev_q & ~rd_data_now;
    assign rd_stat_end = rd_stat_prev_q & ~rd_stat_now;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign pop     = rd_data_end & ~empty;
    // A pop in the same clk frees the head slot, so a push into a full FIFO is accepted then.
    assign push_ok = push_req & (~full | pop);
    assign ovr_set = push_req & full & ~pop;

    assign status  = {4'b0000, ferr_q, ovr_q, full, ~empty};
    assign bus_en  = rnw & (sel_data | sel_status);
    assign bus_val = sel_data ? (empty ? 8'h00 : mem_q[rptr_q]) : status;
    assign io_bus  = bus_en ? bus_val : 'z;

    // Receive FSM: next state, bit timing counter, shift register, push/error requests.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push_req = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_START;
                    cnt_d   = HALF_M1;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                        cnt_d   = FULL_M1;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = FULL_M1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    if (rx_s_q) begin
                        push_req = 1'b1;
                    end else begin
                        ferr_set = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointers, occupancy and sticky flags (a set beats a same-clk clear).
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + COUNT_W'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - COUNT_W'(1);
        end
        ferr_d = ferr_set | (ferr_q & ~rd_stat_end);
        ovr_d  = ovr_set  | (ovr_q  & ~rd_stat_end);
    end

    // State registers, synchronizer and strobe history, with async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            bit_q          <= '0;
            shift_q        <= '0;
            rx_meta_q      <= 1'b1;
            rx_s_q         <= 1'b1;
            rx_prev_q      <= 1'b1;
            rd_data_prev_q <= 1'b0;
            rd_stat_prev_q <= 1'b0;
            ferr_q         <= 1'b0;
            ovr_q          <= 1'b0;
            wptr_q         <= '0;
            rptr_q         <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_q          <= bit_d;
            shift_q        <= shift_d;
            rx_meta_q      <= rx;
            rx_s_q         <= rx_meta_q;
            rx_prev_q      <= rx_s_q;
            rd_data_prev_q <= rd_data_now;
            rd_stat_prev_q <= rd_stat_now;
            ferr_q         <= ferr_d;
            ovr_q          <= ovr_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            count_q        <= count_d;
        end
    end

    // FIFO storage; contents are only visible while occupied, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= shift_q;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized and directed frames checked against a
// queue-based model of the receive FIFO and its status flags.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset, rx, sel_data, sel_status, rnw;
    logic       probe_en;
    logic [7:0] probe_val;
    wire  [7:0] io_bus;

    int checks = 0;
    int errors = 0;

    byte unsigned q[$];
    bit           ferr = 1'b0;
    bit           ovr  = 1'b0;

    assign io_bus = probe_en ? probe_val : 8'bz;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .io_bus     (io_bus),
        .sel_data   (sel_data),
        .sel_status (sel_status),
        .rnw        (rnw)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        return {4'b0000, ferr, ovr, q.size() == DEPTH, q.size() != 0};
    endfunction

    function automatic logic [7:0] exp_head();
        return (q.size() != 0) ? q[0] : 8'h00;
    endfunction

    function automatic void model_frame(input logic [7:0] b, input logic stop);
        if (!stop) ferr = 1'b1;
        else if (q.size() == DEPTH) ovr = 1'b1;
        else q.push_back(b);
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop, input int gap);
        send_frame(b, stop, gap);
        model_frame(b, stop);
    endtask

    task automatic read_data(input string tag);
        @(negedge clk);
        probe_en = 1'b0; sel_data = 1'b1; rnw = 1'b1;
        #1 check(tag, io_bus, exp_head());
        @(negedge clk);
        sel_data = 1'b0;
        @(posedge clk);
        #1;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic read_status(input string tag);
        @(negedge clk);
        probe_en = 1'b0; sel_status = 1'b1; rnw = 1'b1;
        #1 check(tag, io_bus, exp_status());
        @(negedge clk);
        sel_status = 1'b0;
        @(posedge clk);
        #1;
        ferr = 1'b0;
        ovr  = 1'b0;
    endtask

    // Bus must be left undriven by the DUT: the bench's own probe value shows through.
    task automatic bus_idle(input string tag);
        @(negedge clk);
        probe_en  = 1'b1;
        probe_val = 8'($urandom);
        if ($urandom_range(0, 1) == 1) begin
            rnw = 1'b0; sel_data = 1'($urandom); sel_status = 1'($urandom);
        end else begin
            rnw = 1'b1; sel_data = 1'b0; sel_status = 1'b0;
        end
        #1 check(tag, io_bus, probe_val);
        @(negedge clk);
        sel_data = 1'b0; sel_status = 1'b0; rnw = 1'b0;
        @(negedge clk);
        probe_en = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] nb;
        reset = 1'b1; rx = 1'b1; sel_data = 1'b0; sel_status = 1'b0; rnw = 1'b0;
        probe_en = 1'b0; probe_val = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        read_status("rst_status");
        read_data("rst_data");
        bus_idle("rst_z");

        // Single good frame
        rx_byte(8'h41, 1'b1, 4);
        read_status("t1_status");
        read_data("t1_data");
        read_status("t1_status_after");

        // Start-bit glitch
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        read_status("t2_glitch");

        // Framing error
        rx_byte(8'h55, 1'b0, 4);
        read_status("t3_ferr");
        read_status("t3_cleared");
        read_data("t3_empty");

        // Overflow
        for (int i = 0; i < 9; i++) rx_byte(8'(i), 1'b1, 2);
        read_status("t4_full_ovr");
        for (int i = 0; i < 8; i++) read_data($sformatf("t4_data%0d", i));
        read_status("t4_after");

        // Back-to-back frames
        rx_byte(8'hA5, 1'b1, 0);
        rx_byte(8'h3C, 1'b1, 4);
        read_data("t5_a5");
        read_data("t5_3c");

        // Pop ends on the same clk the stop sample pushes into a full FIFO
        for (int i = 0; i < DEPTH; i++) rx_byte(8'($urandom), 1'b1, 2);
        nb = 8'($urandom);
        fork
            send_frame(nb, 1'b1, 4);
            begin
                @(negedge clk);
                repeat (150) @(posedge clk);
                @(negedge clk);
                sel_data = 1'b1; rnw = 1'b1;
                #1 check("t5_coinc_head", io_bus, exp_head());
                repeat (4) @(posedge clk);
                @(negedge clk);
                sel_data = 1'b0;
            end
        join
        void'(q.pop_front());
        q.push_back(nb);
        read_status("t5_coinc_status");
        for (int i = 0; i < DEPTH; i++) read_data($sformatf("t5_drain%0d", i));

        // Reset in the middle of a frame
        rx_byte(8'h77, 1'b1, 4);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        #2 reset = 1'b1;
        q.delete(); ferr = 1'b0; ovr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        read_status("t6_status");
        read_data("t6_data");
        bus_idle("t6_z");
        repeat (120) @(negedge clk);
        rx_byte(8'h12, 1'b1, 4);
        read_data("t6_next");

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 4) rx_byte(8'($urandom), ($urandom_range(0, 7) != 0), $urandom_range(2, 20));
            else if (op <= 6) read_data($sformatf("rnd_data%0d", n));
            else if (op <= 8) read_status($sformatf("rnd_status%0d", n));
            else bus_idle($sformatf("rnd_z%0d", n));
        end
        read_status("end_status");
        for (int i = 0; i <= DEPTH; i++) read_data($sformatf("end_data%0d", i));
        read_status("end_empty");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
